// File: rtl/wb_result_stage_pkg.sv
// Shared encodings for the writeback result stage: source select, load funct3
// codes and the skid-buffer state type.
package wb_result_stage_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_result_stage_load_ext.sv
// wb_load_ext: combinational alignment and sign/zero extension of load data.
// Only instantiated when WB_LOAD_EXT_EN is defined.
module wb_load_ext
    import wb_result_stage_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] read_data_i,
    input  logic [1:0]   offset_i,
    input  logic [2:0]   load_type_i,
    output logic [N-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = read_data_i[7:0];
            2'd1:    byte_sel = read_data_i[15:8];
            2'd2:    byte_sel = read_data_i[23:16];
            default: byte_sel = read_data_i[31:24];
        endcase
        half_sel = offset_i[1] ? read_data_i[31:16] : read_data_i[15:0];
    end

    // Size casts of signed operands sign-extend; of unsigned ones zero-extend.
    always_comb begin
        case (load_type_i)
            LT_LB:   data_o = N'($signed(byte_sel));
            LT_LH:   data_o = N'($signed(half_sel));
            LT_LW:   data_o = N'($signed(read_data_i[31:0]));
            LT_LBU:  data_o = N'(byte_sel);
            LT_LHU:  data_o = N'(half_sel);
            default: data_o = read_data_i;
        endcase
    end

endmodule

// File: rtl/wb_result_stage.sv
// Registered writeback stage: result select, optional load extension
// (WB_LOAD_EXT_EN) and a two-entry skid buffer with valid/ready on both sides.
//
// state | meaning
// EMPTY | M invalid, outputs not valid
// ONE   | M valid, S empty
// FULL  | M and S valid, input stalled
module wb_result_stage
    import wb_result_stage_pkg::*;
#(
    parameter int N    = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ResultSrc,
    input  logic [N-1:0]    ALUResult,
    input  logic [N-1:0]    ReadData,
    input  logic [N-1:0]    PCPlus4,
    input  logic [N-1:0]    ImmExt,
    input  logic [2:0]      LoadType,
    input  logic [RD_W-1:0] RdIn,
    input  logic            RegWriteIn,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    Result,
    output logic [RD_W-1:0] RdOut,
    output logic            RegWriteOut
);

    wb_state_e       state_q, state_d;
    logic [N-1:0]    m_result_q, m_result_d, s_result_q, s_result_d;
    logic [RD_W-1:0] m_rd_q, m_rd_d, s_rd_q, s_rd_d;
    logic            m_we_q, m_we_d, s_we_q, s_we_d;

    logic [N-1:0]    mem_val;
    logic [N-1:0]    sel_result;
    logic            in_we;
    logic            accept;
    logic            drain;

`ifdef WB_LOAD_EXT_EN
    wb_load_ext #(.N(N)) u_load_ext (
        .read_data_i (ReadData),
        .offset_i    (ALUResult[1:0]),
        .load_type_i (LoadType),
        .data_o      (mem_val)
    );
`else
    logic unused_load_type;
    assign unused_load_type = ^LoadType;
    assign mem_val          = ReadData;
`endif

    always_comb begin
        case (ResultSrc)
            RES_ALU: sel_result = ALUResult;
            RES_MEM: sel_result = mem_val;
            RES_PC4: sel_result = PCPlus4;
            default: sel_result = ImmExt;
        endcase
    end

    // Writes to x0 are dropped here so the register file never sees them.
    assign in_we     = RegWriteIn & (RdIn != '0);

    assign in_ready  = (state_q != FULL) & ~reset;
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    assign Result      = m_result_q;
    assign RdOut       = m_rd_q;
    assign RegWriteOut = m_we_q;

    always_comb begin
        state_d    = state_q;
        m_result_d = m_result_q;
        m_rd_d     = m_rd_q;
        m_we_d     = m_we_q;
        s_result_d = s_result_q;
        s_rd_d     = s_rd_q;
        s_we_d     = s_we_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d    = ONE;
                        m_result_d = sel_result;
                        m_rd_d     = RdIn;
                        m_we_d     = in_we;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        m_result_d = sel_result;
                        m_rd_d     = RdIn;
                        m_we_d     = in_we;
                    end else if (accept) begin
                        state_d    = FULL;
                        s_result_d = sel_result;
                        s_rd_d     = RdIn;
                        s_we_d     = in_we;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_d    = ONE;
                        m_result_d = s_result_q;
                        m_rd_d     = s_rd_q;
                        m_we_d     = s_we_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            m_result_q <= '0;
            m_rd_q     <= '0;
            m_we_q     <= 1'b0;
            s_result_q <= '0;
            s_rd_q     <= '0;
            s_we_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_result_q <= m_result_d;
            m_rd_q     <= m_rd_d;
            m_we_q     <= m_we_d;
            s_result_q <= s_result_d;
            s_rd_q     <= s_rd_d;
            s_we_q     <= s_we_d;
        end
    end

endmodule

// File: tb/tb_wb_result_stage.sv
// Bench for wb_result_stage: directed steps plus a random phase, checked
// against a queue-based model of the two-entry buffer.
module tb_wb_result_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready, RegWriteIn;
    logic        in_ready, out_valid, RegWriteOut;
    logic [1:0]  ResultSrc;
    logic [31:0] ALUResult, ReadData, PCPlus4, ImmExt, Result;
    logic [2:0]  LoadType;
    logic [4:0]  RdIn, RdOut;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    ent_t model_q[$];

    always #5 clk = ~clk;

    wb_result_stage #(.N(32), .RD_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ResultSrc   (ResultSrc),
        .ALUResult   (ALUResult),
        .ReadData    (ReadData),
        .PCPlus4     (PCPlus4),
        .ImmExt      (ImmExt),
        .LoadType    (LoadType),
        .RdIn        (RdIn),
        .RegWriteIn  (RegWriteIn),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Result      (Result),
        .RdOut       (RdOut),
        .RegWriteOut (RegWriteOut)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] load_ref(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [2:0] lt);
        logic [31:0] b, h;
        b = (rdata >> (8 * off)) & 32'hFF;
        h = (rdata >> (16 * off[1])) & 32'hFFFF;
`ifdef WB_LOAD_EXT_EN
        case (lt)
            3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rdata;
        endcase
`else
        if (lt == 3'd7 && b == 32'hFFFF && h == 32'd0) return 32'd0;
        return rdata;
`endif
    endfunction

    function automatic ent_t ref_entry();
        ent_t e;
        case (ResultSrc)
            2'd0:    e.res = ALUResult;
            2'd1:    e.res = load_ref(ReadData, ALUResult[1:0], LoadType);
            2'd2:    e.res = PCPlus4;
            default: e.res = ImmExt;
        endcase
        e.rd = RdIn;
        e.we = RegWriteIn && (RdIn != 5'd0);
        return e;
    endfunction

    // Check outputs mid-cycle, then advance the model and the DUT one edge.
    task automatic cycle();
        bit acc, drn;
        ent_t e;
        @(negedge clk);
        chk("out_valid", out_valid, (model_q.size() > 0));
        chk("in_ready", in_ready, (model_q.size() < 2) && !reset);
        if (model_q.size() > 0) begin
            chk("Result", Result, model_q[0].res);
            chk("RdOut", RdOut, model_q[0].rd);
            chk("RegWriteOut", RegWriteOut, model_q[0].we);
        end
        e = ref_entry();
        if (reset || flush) begin
            model_q.delete();
        end else begin
            acc = in_valid && (model_q.size() < 2);
            drn = (model_q.size() > 0) && out_ready;
            if (drn) void'(model_q.pop_front());
            if (acc) model_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] pc4, input logic [31:0] imm,
                         input logic [2:0] lt, input logic [4:0] rd, input logic we);
        in_valid   = v;
        ResultSrc  = src;
        ALUResult  = alu;
        ReadData   = rdata;
        PCPlus4    = pc4;
        ImmExt     = imm;
        LoadType   = lt;
        RdIn       = rd;
        RegWriteIn = we;
    endtask

    logic [31:0] exp_ld [4];
    logic [31:0] src_exp [4];

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 2'd0, 32'h99, 32'h0, 32'h0, 32'h0, 3'd2, 5'd3, 1'b1);

        // Reset held two cycles with in_valid high
        cycle();
        cycle();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_Result", Result, 32'h0);
        chk("rst_RdOut", RdOut, 5'd0);
        chk("rst_RegWriteOut", RegWriteOut, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        cycle();
        chk("post_rst_empty", out_valid, 1'b0);

        // Source select streaming
        src_exp[0] = 32'h11; src_exp[1] = 32'h22; src_exp[2] = 32'h33; src_exp[3] = 32'h44000;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 32'h11, 32'h22, 32'h33, 32'h44000, 3'd2, 5'(i + 1), 1'b1);
            cycle();
            chk("src_valid", out_valid, 1'b1);
            chk("src_result", Result, src_exp[i]);
        end
        in_valid = 1'b0;
        cycle();
        chk("src_drained", out_valid, 1'b0);

        // Back-pressure: A, B fill the buffer, C is held off
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 32'hA, 32'h0, 32'h0, 32'h0, 3'd2, 5'd1, 1'b1);
        cycle();
        drive(1'b1, 2'd0, 32'hB, 32'h0, 32'h0, 32'h0, 3'd2, 5'd2, 1'b1);
        cycle();
        chk("bp_full_in_ready", in_ready, 1'b0);
        chk("bp_head", Result, 32'hA);
        drive(1'b1, 2'd0, 32'hC, 32'h0, 32'h0, 32'h0, 3'd2, 5'd3, 1'b1);
        cycle();
        chk("bp_hold", Result, 32'hA);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_first", Result, 32'hA);
        cycle();
        chk("bp_second", Result, 32'hB);
        chk("bp_second_v", out_valid, 1'b1);
        cycle();
        chk("bp_empty", out_valid, 1'b0);

        // x0 suppression
        drive(1'b1, 2'd0, 32'h5, 32'h0, 32'h0, 32'h0, 3'd2, 5'd0, 1'b1);
        cycle();
        chk("x0_we", RegWriteOut, 1'b0);
        drive(1'b1, 2'd0, 32'h6, 32'h0, 32'h0, 32'h0, 3'd2, 5'd5, 1'b1);
        cycle();
        chk("x5_we", RegWriteOut, 1'b1);
        chk("x5_rd", RdOut, 5'd5);

        // Load alignment / extension
`ifdef WB_LOAD_EXT_EN
        exp_ld[0] = 32'hFFFF_FFF7; exp_ld[1] = 32'h0000_0080;
        exp_ld[2] = 32'hFFFF_80F7; exp_ld[3] = 32'h0000_7F01;
`else
        exp_ld[0] = 32'h80F7_7F01; exp_ld[1] = 32'h80F7_7F01;
        exp_ld[2] = 32'h80F7_7F01; exp_ld[3] = 32'h80F7_7F01;
`endif
        drive(1'b1, 2'd1, 32'h2, 32'h80F7_7F01, 32'h0, 32'h0, 3'b000, 5'd7, 1'b1);
        cycle();
        chk("ld_lb_off2", Result, exp_ld[0]);
        drive(1'b1, 2'd1, 32'h3, 32'h80F7_7F01, 32'h0, 32'h0, 3'b100, 5'd7, 1'b1);
        cycle();
        chk("ld_lbu_off3", Result, exp_ld[1]);
        drive(1'b1, 2'd1, 32'h2, 32'h80F7_7F01, 32'h0, 32'h0, 3'b001, 5'd7, 1'b1);
        cycle();
        chk("ld_lh_off2", Result, exp_ld[2]);
        drive(1'b1, 2'd1, 32'h0, 32'h80F7_7F01, 32'h0, 32'h0, 3'b101, 5'd7, 1'b1);
        cycle();
        chk("ld_lhu_off0", Result, exp_ld[3]);
        in_valid = 1'b0;
        cycle();

        // Flush while FULL with a simultaneous in_valid
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 32'hD1, 32'h0, 32'h0, 32'h0, 3'd2, 5'd1, 1'b1);
        cycle();
        drive(1'b1, 2'd0, 32'hD2, 32'h0, 32'h0, 32'h0, 3'd2, 5'd2, 1'b1);
        cycle();
        chk("fl_full", in_ready, 1'b0);
        flush = 1'b1;
        drive(1'b1, 2'd0, 32'hD3, 32'h0, 32'h0, 32'h0, 3'd2, 5'd3, 1'b1);
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        cycle();
        chk("fl_nothing", out_valid, 1'b0);

        // Random phase
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
                  $urandom, $urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_result_stage.md
# wb_result_stage

Registered, flow-controlled writeback stage for the RISC-V core. It selects the register-file write value from four sources: ALU result, load data, PC+4 and the extended immediate. It optionally aligns and extends sub-word load data, then holds the result in a two-entry skid buffer with valid/ready handshakes on both sides. It sits between the memory stage and the register-file write port, and supersedes the purely combinational result multiplexer once the core is pipelined.

## Interface
- N, 32, datapath width; must be ≥ 32.
- RD_W, 5, destination-register index width.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous clear of all buffered entries.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid & in_ready.
- ResultSrc  in  2  00 ALUResult, 01 ReadData, 10 PCPlus4, 11 ImmExt.
- ALUResult  in  N  ALU output; bits [1:0] are also the load byte offset.
- ReadData  in  N  raw data-memory word.
- PCPlus4  in  N  link value.
- ImmExt  in  N  extended immediate (LUI).
- LoadType  in  3  load funct3.
- RdIn  in  RD_W  destination register.
- RegWriteIn  in  1  write enable.
- out_valid  out  1  Result/RdOut/RegWriteOut are valid.
- out_ready  in  1  consumer takes the entry; a drain occurs when out_valid & out_ready.
- Result  out  N  selected writeback value.
- RdOut  out  RD_W  destination register.
- RegWriteOut  out  1  write enable; forced 0 when RdOut == 0.

## Operation
- The result is selected combinationally at the input, then captured with RdIn and RegWriteIn. RegWriteIn & (RdIn != 0) is stored as the write enable.
- Storage has two entries. The main register M drives the outputs; the skid register S backs it up.
- State machine: EMPTY (M invalid), ONE (M valid, S empty), FULL (both valid).
  - EMPTY, on accept → ONE; M loads the input.
  - ONE, accept & drain → ONE; M loads the input.
  - ONE, accept & no drain → FULL; S loads the input.
  - ONE, drain & no accept → EMPTY.
  - FULL, drain → ONE; M loads S.
  - FULL, no drain → FULL; all registers hold.
- in_ready = (state != FULL) & ~reset. It is a function of registered state only; there is no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Output registers hold their value while out_valid & ~out_ready. Contents are stable until the entry drains.
- flush takes priority over accept and drain. The next state is EMPTY, and any transfer presented in that cycle is discarded. Data registers hold their old contents, but out_valid = 0.
- reset takes priority over flush.

## Timing
- Latency: an entry accepted at edge k appears on the outputs after edge k (out_valid = 1 in cycle k+1), provided the stage was EMPTY or draining.
- Throughput is one entry per cycle with out_ready held high. A single out_ready stall costs no input bubble, because S absorbs the entry.
- Reset values: state EMPTY, in_ready 0 while reset is asserted and 1 afterwards, out_valid 0, Result 0, RdOut 0, RegWriteOut 0, and S cleared to 0.
- Reset or flush asserted mid-stream: all entries are lost, and no drain is reported in that cycle.

## Configuration
- WB_LOAD_EXT_EN defined: when ResultSrc = 01, ReadData is aligned and extended before capture.
  - LB (000): byte at ALUResult[1:0], sign-extended to N.
  - LH (001): half at ALUResult[1], sign-extended.
  - LW (010): low 32 bits, sign-extended.
  - LBU (100): byte, zero-extended.
  - LHU (101): half, zero-extended.
  - Other codes: ReadData unchanged.
- WB_LOAD_EXT_EN undefined: ReadData passes through raw, and LoadType is ignored.

## Structure
- Shared package holds:
  - the ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4, RES_IMM);
  - the LoadType funct3 constants;
  - the state typedef (EMPTY, ONE, FULL).
- One sub-module, wb_load_ext: purely combinational alignment and extension, instantiated only under WB_LOAD_EXT_EN.

## Test plan
- Reset: assert reset for 2 cycles while in_valid = 1 → out_valid 0, Result 0, and nothing accepted. After release, in_ready = 1.
- Source select, streaming with out_ready = 1:
  - ResultSrc 00/01/10/11, each with a distinct value (ALUResult 0x11, ReadData 0x22, PCPlus4 0x33, ImmExt 0x44000) → outputs 0x11, 0x22, 0x33, 0x44000 on consecutive cycles, each one cycle after accept.
- Back-pressure:
  - Two entries accepted while out_ready = 0 → state FULL and in_ready = 0.
  - A third in_valid is held off.
  - Raising out_ready → entries drain in order, one per cycle, with no loss or duplication.
- x0 suppression: RdIn 0 with RegWriteIn 1 → RegWriteOut 0; RdIn 5 → RegWriteOut 1.
- Load extension (macro defined), ReadData 0x80F7_7F01:
  - LB, offset 2 → 0xFFFF_FFF7.
  - LBU, offset 3 → 0x0000_0080.
  - LH, offset 2 → 0xFFFF_80F7.
  - LHU, offset 0 → 0x0000_7F01.
  - Macro undefined → 0x80F7_7F01.
- Flush while FULL with a simultaneous in_valid → next cycle out_valid 0 and in_ready 1, and the flushed and presented entries never appear.
